// File: rtl/rv32i_types.sv
// Shared RV32 encodings used by the execute cluster: ALU ops, branch compares,
// execute-unit kinds and multiplier result selects.
package rv32i_types;

  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3;

  typedef enum logic [1:0] {
    fu_alu = 2'b00,
    fu_cmp = 2'b01,
    fu_mul = 2'b10,
    fu_ill = 2'b11
  } fu_kind_t;

  typedef enum logic [1:0] {
    mul_lo  = 2'b00,
    mul_h   = 2'b01,
    mul_hsu = 2'b10,
    mul_hu  = 2'b11
  } mul_type_t;

endpackage

// File: rtl/fu_lane.sv
// One execute lane: 1-cycle ALU/CMP stage, non-stalling multiplier pipe and a
// first-word-fall-through result FIFO whose free slots are handed out as issue credits.
module fu_lane
  import rv32i_types::*;
#(
  parameter int XLEN       = 32,
  parameter int TAG_W      = 8,
  parameter int MUL_STAGES = 3,
  parameter int OUT_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             iss_valid,
  output logic             iss_ready,
  input  logic [1:0]       iss_kind,
  input  logic [2:0]       iss_op,
  input  logic [XLEN-1:0]  iss_a,
  input  logic [XLEN-1:0]  iss_b,
  input  logic [TAG_W-1:0] iss_tag,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [XLEN-1:0]  wb_value,
  output logic [TAG_W-1:0] wb_tag,
  output logic             mul_busy
);

  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = $clog2(OUT_DEPTH + MUL_STAGES + 2) + 1;
  localparam int SW = $clog2(XLEN);

  function automatic logic [XLEN-1:0] alu_f(input logic [2:0] op, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic [SW-1:0] sh;
    sh = b[SW-1:0];
    case (alu_ops'(op))
      alu_add: return a + b;
      alu_sll: return a << sh;
      alu_sra: return $unsigned($signed(a) >>> sh);
      alu_sub: return a - b;
      alu_xor: return a ^ b;
      alu_srl: return a >> sh;
      alu_or:  return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic cmp_f(input logic [2:0] op, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b);
    case (branch_funct3'(op))
      beq:     return a == b;
      bne:     return a != b;
      blt:     return $signed(a) < $signed(b);
      bge:     return $signed(a) >= $signed(b);
      bltu:    return a < b;
      bgeu:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Extending to 2*XLEN yields the same low 2*XLEN product bits as the XLEN+1 form.
  function automatic logic [XLEN-1:0] mul_f(input logic [1:0] op, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic              sa, sb;
    logic [2*XLEN-1:0] ae, be, p;
    sa = (mul_type_t'(op) == mul_h) || (mul_type_t'(op) == mul_hsu);
    sb = (mul_type_t'(op) == mul_h);
    ae = {{XLEN{sa & a[XLEN-1]}}, a};
    be = {{XLEN{sb & b[XLEN-1]}}, b};
    p  = ae * be;
    return (mul_type_t'(op) == mul_lo) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  fu_kind_t                          kind;
  logic                              acc, acc_mul, acc_alu;
  logic [XLEN-1:0]                   alu_res;
  logic                              alu_v;
  logic [XLEN-1:0]                   alu_val;
  logic [TAG_W-1:0]                  alu_tag;
  logic [MUL_STAGES-1:0]             mul_v;
  logic [MUL_STAGES-1:0][XLEN-1:0]   mul_val;
  logic [MUL_STAGES-1:0][TAG_W-1:0]  mul_tag;
  logic [OUT_DEPTH-1:0][XLEN-1:0]    fifo_val;
  logic [OUT_DEPTH-1:0][TAG_W-1:0]   fifo_tag;
  logic [PW-1:0]                     rptr, wptr, wptr_a;
  logic [PW:0]                       count;
  logic                              push_m, push_a, pop;
  logic [CW-1:0]                     used;

  assign kind    = fu_kind_t'(iss_kind);
  assign acc     = iss_valid & iss_ready;
  assign acc_mul = acc & (kind == fu_mul);
  assign acc_alu = acc & (kind != fu_mul);

  always_comb begin
    alu_res = '0;
    case (kind)
      fu_alu:  alu_res = alu_f(iss_op, iss_a, iss_b);
      fu_cmp:  alu_res = {{(XLEN-1){1'b0}}, cmp_f(iss_op, iss_a, iss_b)};
      default: alu_res = '0;
    endcase
  end

  // Slots already promised to work still in the ALU stage or multiplier pipe.
  always_comb begin
    used = CW'(count) + CW'(alu_v);
    for (int i = 0; i < MUL_STAGES; i++) used = used + CW'(mul_v[i]);
  end

  assign iss_ready = (used < CW'(OUT_DEPTH)) & ~flush;
  assign push_m    = mul_v[MUL_STAGES-1];
  assign push_a    = alu_v;
  assign wptr_a    = wptr + PW'(push_m);
  assign wb_valid  = (count != '0);
  assign pop       = wb_valid & wb_ready;
  assign wb_value  = wb_valid ? fifo_val[rptr] : '0;
  assign wb_tag    = wb_valid ? fifo_tag[rptr] : '0;
  assign mul_busy  = |mul_v;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_v    <= 1'b0;
      alu_val  <= '0;
      alu_tag  <= '0;
      mul_v    <= '0;
      mul_val  <= '0;
      mul_tag  <= '0;
      fifo_val <= '0;
      fifo_tag <= '0;
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
    end else if (flush) begin
      alu_v <= 1'b0;
      mul_v <= '0;
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      alu_v      <= acc_alu;
      alu_val    <= alu_res;
      alu_tag    <= iss_tag;
      mul_v[0]   <= acc_mul;
      mul_val[0] <= mul_f(iss_op[1:0], iss_a, iss_b);
      mul_tag[0] <= iss_tag;
      for (int i = 1; i < MUL_STAGES; i++) begin
        mul_v[i]   <= mul_v[i-1];
        mul_val[i] <= mul_val[i-1];
        mul_tag[i] <= mul_tag[i-1];
      end
      // Multiplier result takes the first free slot so it pops ahead of a same-cycle ALU result.
      if (push_m) begin
        fifo_val[wptr] <= mul_val[MUL_STAGES-1];
        fifo_tag[wptr] <= mul_tag[MUL_STAGES-1];
      end
      if (push_a) begin
        fifo_val[wptr_a] <= alu_val;
        fifo_tag[wptr_a] <= alu_tag;
      end
      wptr  <= wptr_a + PW'(push_a);
      rptr  <= rptr + PW'(pop);
      count <= count + (PW+1)'(push_m) + (PW+1)'(push_a) - (PW+1)'(pop);
    end
  end

endmodule

// File: rtl/fu_cluster.sv
// Execute cluster: SS independent fu_lane instances between issue ports and writeback.
module fu_cluster #(
  parameter int SS         = 2,
  parameter int XLEN       = 32,
  parameter int TAG_W      = 8,
  parameter int MUL_STAGES = 3,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [SS-1:0]            iss_valid,
  output logic [SS-1:0]            iss_ready,
  input  logic [SS-1:0][1:0]       iss_kind,
  input  logic [SS-1:0][2:0]       iss_op,
  input  logic [SS-1:0][XLEN-1:0]  iss_a,
  input  logic [SS-1:0][XLEN-1:0]  iss_b,
  input  logic [SS-1:0][TAG_W-1:0] iss_tag,
  output logic [SS-1:0]            wb_valid,
  input  logic [SS-1:0]            wb_ready,
  output logic [SS-1:0][XLEN-1:0]  wb_value,
  output logic [SS-1:0][TAG_W-1:0] wb_tag,
  output logic [SS-1:0]            mul_busy
);

  for (genvar l = 0; l < SS; l++) begin : g_lane
    fu_lane #(
      .XLEN      (XLEN),
      .TAG_W     (TAG_W),
      .MUL_STAGES(MUL_STAGES),
      .OUT_DEPTH (OUT_DEPTH)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .iss_valid(iss_valid[l]),
      .iss_ready(iss_ready[l]),
      .iss_kind (iss_kind[l]),
      .iss_op   (iss_op[l]),
      .iss_a    (iss_a[l]),
      .iss_b    (iss_b[l]),
      .iss_tag  (iss_tag[l]),
      .wb_valid (wb_valid[l]),
      .wb_ready (wb_ready[l]),
      .wb_value (wb_value[l]),
      .wb_tag   (wb_tag[l]),
      .mul_busy (mul_busy[l])
    );
  end

endmodule

// File: tb/tb_fu_cluster.sv
// Bench for fu_cluster: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of completion times and result FIFOs.
module tb_fu_cluster;

  localparam int SS = 2, XLEN = 32, TAG_W = 8, MS = 3, DEPTH = 4;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic [SS-1:0]            iss_valid, iss_ready, wb_valid, wb_ready, mul_busy;
  logic [SS-1:0][1:0]       iss_kind;
  logic [SS-1:0][2:0]       iss_op;
  logic [SS-1:0][XLEN-1:0]  iss_a, iss_b, wb_value;
  logic [SS-1:0][TAG_W-1:0] iss_tag, wb_tag;

  int n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  fu_cluster #(.SS(SS), .XLEN(XLEN), .TAG_W(TAG_W), .MUL_STAGES(MS), .OUT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_kind(iss_kind), .iss_op(iss_op),
    .iss_a(iss_a), .iss_b(iss_b), .iss_tag(iss_tag),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_value(wb_value), .wb_tag(wb_tag),
    .mul_busy(mul_busy)
  );

  typedef struct {int land; bit is_mul; logic [31:0] val; logic [7:0] tag;} pend_t;
  typedef struct {logic [31:0] val; logic [7:0] tag;} res_t;

  pend_t pend[SS][$];
  res_t  fq[SS][$];
  int    cyc = 0;

  task automatic chk(input string nm, input int lane, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s lane%0d: got %h want %h at %0t", nm, lane, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] kind, input logic [2:0] op,
                                             input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (kind)
      2'b00: case (op)
        3'd0: return a + b;
        3'd1: return a << b[4:0];
        3'd2: return $unsigned($signed(a) >>> b[4:0]);
        3'd3: return a - b;
        3'd4: return a ^ b;
        3'd5: return a >> b[4:0];
        3'd6: return a | b;
        default: return a & b;
      endcase
      2'b01: case (op)
        3'd0: return (a == b) ? 32'd1 : 32'd0;
        3'd1: return (a != b) ? 32'd1 : 32'd0;
        3'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd5: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
        3'd6: return (a < b) ? 32'd1 : 32'd0;
        3'd7: return (a >= b) ? 32'd1 : 32'd0;
        default: return 32'd0;
      endcase
      2'b10: begin
        case (op[1:0])
          2'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
          2'd1: p = longint'($signed(a)) * longint'($signed(b));
          2'd2: p = longint'($signed(a)) * longint'({32'd0, b});
          default: p = {32'd0, a} * {32'd0, b};
        endcase
        return p[63:32];
      end
      default: return 32'd0;
    endcase
  endfunction

  // Model: each accepted op lands in its lane queue at accept edge + latency.
  always @(negedge clk) begin
    int edge_i;
    #1;
    edge_i = cyc + 1;
    for (int l = 0; l < SS; l++) begin
      if (!rst) begin
        pend[l].delete();
        fq[l].delete();
        chk("rst_wb_valid", l, 32'(wb_valid[l]), 32'd0);
        chk("rst_wb_value", l, wb_value[l], 32'd0);
        chk("rst_wb_tag", l, 32'(wb_tag[l]), 32'd0);
        chk("rst_mul_busy", l, 32'(mul_busy[l]), 32'd0);
      end else begin : lane_model
        bit    ev, er, eb;
        pend_t keep[$];
        keep.delete();
        ev = fq[l].size() > 0;
        er = (DEPTH - fq[l].size() - pend[l].size() >= 1) && !flush;
        eb = 1'b0;
        foreach (pend[l][k]) if (pend[l][k].is_mul) eb = 1'b1;
        chk("wb_valid", l, 32'(wb_valid[l]), 32'(ev));
        if (ev) begin
          chk("wb_value", l, wb_value[l], fq[l][0].val);
          chk("wb_tag", l, 32'(wb_tag[l]), 32'(fq[l][0].tag));
        end
        chk("iss_ready", l, 32'(iss_ready[l]), 32'(er));
        chk("mul_busy", l, 32'(mul_busy[l]), 32'(eb));
        if (flush) begin
          pend[l].delete();
          fq[l].delete();
        end else begin
          if (ev && wb_ready[l]) void'(fq[l].pop_front());
          foreach (pend[l][k])
            if (pend[l][k].land == edge_i && pend[l][k].is_mul)
              fq[l].push_back('{val: pend[l][k].val, tag: pend[l][k].tag});
          foreach (pend[l][k])
            if (pend[l][k].land == edge_i && !pend[l][k].is_mul)
              fq[l].push_back('{val: pend[l][k].val, tag: pend[l][k].tag});
          foreach (pend[l][k]) if (pend[l][k].land != edge_i) keep.push_back(pend[l][k]);
          pend[l] = keep;
          if (iss_valid[l] && er)
            pend[l].push_back('{land: edge_i + ((iss_kind[l] == 2'b10) ? MS : 1),
                                is_mul: (iss_kind[l] == 2'b10),
                                val: ref_result(iss_kind[l], iss_op[l], iss_a[l], iss_b[l]),
                                tag: iss_tag[l]});
        end
      end
    end
    cyc = edge_i;
  end

  task automatic iss0(input logic v, input logic [1:0] k, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic [7:0] t);
    iss_valid[0] = v; iss_kind[0] = k; iss_op[0] = op;
    iss_a[0] = a; iss_b[0] = b; iss_tag[0] = t;
  endtask

  task automatic wait_wb(input string nm, input logic [31:0] ev, input logic [7:0] et);
    int k = 0;
    while (!wb_valid[0] && k < 12) begin
      @(negedge clk); #2; k++;
    end
    chk({nm, "_present"}, 0, 32'(wb_valid[0]), 32'd1);
    chk({nm, "_value"}, 0, wb_value[0], ev);
    chk({nm, "_tag"}, 0, 32'(wb_tag[0]), 32'(et));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int acc_n;
    iss_valid = '0; iss_kind = '0; iss_op = '0; iss_a = '0; iss_b = '0; iss_tag = '0;
    wb_ready = '0;
    #3 rst = 1'b0;
    @(negedge clk); @(negedge clk); #2;
    for (int l = 0; l < SS; l++) chk("init_wb_valid", l, 32'(wb_valid[l]), 32'd0);
    @(negedge clk); rst = 1'b1; wb_ready = 2'b11; #2;
    for (int l = 0; l < SS; l++) chk("init_ready", l, 32'(iss_ready[l]), 32'd1);

    // ALU add 5+7
    @(negedge clk); iss0(1, 2'b00, 3'd0, 32'd5, 32'd7, 8'h11); #2;
    chk("add_ready", 0, 32'(iss_ready[0]), 32'd1);
    @(negedge clk); iss0(0, 0, 0, 0, 0, 0); #2;
    chk("add_early", 0, 32'(wb_valid[0]), 32'd0);
    @(negedge clk); #2;
    chk("add_valid", 0, 32'(wb_valid[0]), 32'd1);
    chk("add_value", 0, wb_value[0], 32'd12);
    chk("add_tag", 0, 32'(wb_tag[0]), 32'h11);
    @(negedge clk); #2;
    chk("add_popped", 0, 32'(wb_valid[0]), 32'd0);

    // MUL / MULH / MULHU of all-ones
    @(negedge clk); iss0(1, 2'b10, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h01);
    @(negedge clk); iss0(1, 2'b10, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h02);
    @(negedge clk); iss0(1, 2'b10, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h03);
    @(negedge clk); iss0(0, 0, 0, 0, 0, 0); #2;
    chk("mul_not_early", 0, 32'(wb_valid[0]), 32'd0);
    @(negedge clk); #2; wait_wb("mul", 32'h0000_0001, 8'h01);
    @(negedge clk); #2; wait_wb("mulh", 32'h0000_0000, 8'h02);
    @(negedge clk); #2; wait_wb("mulhu", 32'hFFFF_FFFE, 8'h03);
    @(negedge clk); #2;
    chk("mul_drained", 0, 32'(wb_valid[0]), 32'd0);

    // Collision: MUL and ADD complete on the same edge
    @(negedge clk); wb_ready[0] = 1'b0; iss0(1, 2'b10, 3'd0, 32'd3, 32'd4, 8'h20);
    @(negedge clk); iss0(0, 0, 0, 0, 0, 0);
    @(negedge clk); iss0(1, 2'b00, 3'd0, 32'd1, 32'd2, 8'h21);
    @(negedge clk); iss0(0, 0, 0, 0, 0, 0); #2;
    chk("coll_early", 0, 32'(wb_valid[0]), 32'd0);
    @(negedge clk); wb_ready[0] = 1'b1; #2; wait_wb("coll_mul", 32'd12, 8'h20);
    @(negedge clk); #2; wait_wb("coll_add", 32'd3, 8'h21);
    @(negedge clk); #2;
    chk("coll_drained", 0, 32'(wb_valid[0]), 32'd0);

    // Back-pressure: issue every cycle with writeback stalled
    acc_n = 0;
    @(negedge clk); wb_ready[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      iss0(1, 2'b00, 3'd0, 32'(i * 10), 32'd1, 8'(8'h40 + i)); #2;
      if (iss_ready[0]) acc_n++;
    end
    @(negedge clk); iss0(0, 0, 0, 0, 0, 0); #2;
    chk("bp_accepted", 0, 32'(acc_n), 32'd4);
    chk("bp_full_ready", 0, 32'(iss_ready[0]), 32'd0);
    @(negedge clk); wb_ready[0] = 1'b1; #2;
    for (int j = 0; j < 4; j++) begin
      wait_wb("bp_drain", 32'(j * 10 + 1), 8'(8'h40 + j));
      @(negedge clk); #2;
    end
    chk("bp_no_dup", 0, 32'(wb_valid[0]), 32'd0);

    // Flush with one FIFO entry and two MULs in flight
    @(negedge clk); wb_ready[0] = 1'b0; iss0(1, 2'b00, 3'd0, 32'd9, 32'd9, 8'h50);
    @(negedge clk); iss0(1, 2'b10, 3'd0, 32'd2, 32'd3, 8'h51);
    @(negedge clk); iss0(1, 2'b10, 3'd0, 32'd2, 32'd3, 8'h52);
    @(negedge clk); iss0(0, 0, 0, 0, 0, 0); flush = 1'b1; #2;
    chk("pre_flush_valid", 0, 32'(wb_valid[0]), 32'd1);
    chk("pre_flush_busy", 0, 32'(mul_busy[0]), 32'd1);
    chk("flush_ready", 0, 32'(iss_ready[0]), 32'd0);
    @(negedge clk); flush = 1'b0; #2;
    chk("flush_valid", 0, 32'(wb_valid[0]), 32'd0);
    chk("flush_busy", 0, 32'(mul_busy[0]), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); wb_ready[0] = 1'b1; #2;
      chk("flush_late", 0, 32'(wb_valid[0]), 32'd0);
    end

    // Reset mid-run
    @(negedge clk); wb_ready[0] = 1'b0; iss0(1, 2'b00, 3'd0, 32'd1, 32'd1, 8'h60);
    @(negedge clk); iss0(1, 2'b00, 3'd0, 32'd2, 32'd2, 8'h61);
    @(negedge clk); iss0(0, 0, 0, 0, 0, 0); rst = 1'b0; #2;
    chk("midrst_valid", 0, 32'(wb_valid[0]), 32'd0);
    @(negedge clk); rst = 1'b1; #2;
    chk("midrst_valid_after", 0, 32'(wb_valid[0]), 32'd0);
    chk("midrst_ready", 0, 32'(iss_ready[0]), 32'd1);

    // Random traffic on both lanes
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      for (int l = 0; l < SS; l++) begin
        iss_valid[l] = ($urandom_range(0, 9) < 6);
        iss_kind[l]  = 2'($urandom_range(0, 3));
        iss_op[l]    = 3'($urandom_range(0, 7));
        iss_a[l]     = pick();
        iss_b[l]     = pick();
        iss_tag[l]   = 8'($urandom);
        wb_ready[l]  = ($urandom_range(0, 9) < 7);
      end
      flush = ($urandom_range(0, 49) == 0);
    end
    @(negedge clk);
    iss_valid = '0; flush = 1'b0; wb_ready = '1;
    repeat (10) @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
